matmul_tile_engine: RTL and testbench

- Parametrised N x N matrix-multiply engine that computes C = A x B.
- A, B and C sit in external synchronous RAMs. The engine owns address generation, LANES parallel MAC lanes, the C write-back buffer, the run FSM and the cycle counter.
- It is the generalised successor of the fixed 8x8, two-MAC multiplier: configurable size, width and lane count, plus signed/unsigned mode, abort, and a single shared A read per cycle broadcast to all lanes.

---
 rtl/matmul_pkg.sv | 27 ++
 rtl/mac_lane.sv | 54 +++++
 rtl/matmul_tile_engine.sv | 223 ++++++++++++++++++++++
 tb/tb_matmul_tile_engine.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply tile engine.
// Contents: run-FSM state enum, accumulator width derivation, and the
// parameter legality check used at elaboration time.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Wide enough that N products of two DATA_W operands never overflow.
  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned n);
    return 2 * data_w + $clog2(n);
  endfunction

  // N a power of two >= 2; LANES a power of two that divides N.
  function automatic bit params_ok(input int unsigned n, input int unsigned lanes);
    return is_pow2(n) && (n >= 2) && is_pow2(lanes) && (lanes <= n);
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One multiply-accumulate lane.
// Ports: clk/reset (sync, active-high); clear zeroes the accumulator;
// en marks a valid operand pair; load restarts the sum with this product;
// signed_mode selects two's-complement operands; a/b operands;
// sum_c is the combinational running sum including the current product.
module mac_lane #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic              load,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  sum_c
);

  localparam int unsigned PW = 2 * DATA_W + 2;

  logic signed [DATA_W:0] a_ext;
  logic signed [DATA_W:0] b_ext;
  logic signed [PW-1:0]   prod;
  logic [ACC_W-1:0]       prod_ext;
  logic [ACC_W-1:0]       acc_q;
  logic [ACC_W-1:0]       acc_d;

  // One extra bit lets a single signed multiplier serve both modes.
  assign a_ext    = {signed_mode & a[DATA_W-1], a};
  assign b_ext    = {signed_mode & b[DATA_W-1], b};
  assign prod     = a_ext * b_ext;
  assign prod_ext = ACC_W'(prod);
  assign sum_c    = load ? prod_ext : acc_q + prod_ext;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matmul_tile_engine.sv
// N x N matrix multiply C = A x B over external synchronous RAMs.
// Ports: clk/reset (sync, active-high); start/abort run control;
// signed_mode operand format (latched at start); busy/done status;
// cycle_count busy cycles of current/last run; a_addr/a_rdata shared A read;
// b_addr/b_rdata per-lane B reads; c_we/c_addr/c_wdata C write-back.
module matmul_tile_engine
  import matmul_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 2,
  parameter int unsigned AW     = $clog2(N * N),
  parameter int unsigned ACC_W  = acc_w(DATA_W, N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    signed_mode,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             cycle_count,
  output logic [AW-1:0]           a_addr,
  input  logic [DATA_W-1:0]       a_rdata,
  output logic [LANES*AW-1:0]     b_addr,
  input  logic [LANES*DATA_W-1:0] b_rdata,
  output logic                    c_we,
  output logic [AW-1:0]           c_addr,
  output logic [ACC_W-1:0]        c_wdata
);

  localparam int unsigned KW  = $clog2(N);
  localparam int unsigned G   = N / LANES;
  localparam int unsigned GW  = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned DCW = $clog2(LANES) + 1;

  if (!params_ok(N, LANES)) begin : g_param_check
    $error("matmul_tile_engine: N must be a power of two >= 2 and LANES a power of two <= N");
  end

  state_e                 state_q, state_d;
  logic [KW-1:0]          i_q, i_d;
  logic [KW-1:0]          k_q, k_d;
  logic [GW-1:0]          g_q, g_d;
  logic                   sm_q, sm_d;
  logic                   vld_q, vld_d;
  logic                   first_q, first_d;
  logic                   last_q, last_d;
  logic [AW-1:0]          base_q, base_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [31:0]            cnt_q, cnt_d;
  logic                   c_we_q, c_we_d;
  logic [AW-1:0]          c_addr_q, c_addr_d;
  logic [ACC_W-1:0]       c_wdata_q, c_wdata_d;
  logic [LANES*ACC_W-1:0] drain_q, drain_d;
  logic [DCW-1:0]         drain_cnt_q, drain_cnt_d;
  logic [LANES*ACC_W-1:0] sum_flat;
  logic                   lane_clr;

  assign busy        = busy_q;
  assign done        = done_q;
  assign cycle_count = cnt_q;
  assign c_we        = c_we_q;
  assign c_addr      = c_addr_q;
  assign c_wdata     = c_wdata_q;

  // Issue addresses: A element (i,k) shared, B element (k, g*LANES+l) per lane.
  always_comb begin
    a_addr = '0;
    b_addr = '0;
    if (state_q == RUN) begin
      a_addr = {i_q, k_q};
      for (int l = 0; l < LANES; l++) begin
        b_addr[l*AW +: AW] = {k_q, KW'(32'(g_q) * LANES + 32'(l))};
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_mac (
      .clk         (clk),
      .reset       (reset),
      .clear       (lane_clr),
      .en          (vld_q),
      .load        (first_q),
      .signed_mode (sm_q),
      .a           (a_rdata),
      .b           (b_rdata[l*DATA_W +: DATA_W]),
      .sum_c       (sum_flat[l*ACC_W +: ACC_W])
    );
  end

  // Run FSM, issue counters, drain buffer and status.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    k_d         = k_q;
    g_d         = g_q;
    sm_d        = sm_q;
    vld_d       = 1'b0;
    first_d     = first_q;
    last_d      = last_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    c_we_d      = 1'b0;
    c_addr_d    = c_addr_q;
    c_wdata_d   = c_wdata_q;
    drain_d     = drain_q;
    drain_cnt_d = drain_cnt_q;
    lane_clr    = 1'b0;

    // Capture writes lane 0 immediately; remaining lanes shift out behind it.
    if (vld_q && last_q) begin
      c_we_d      = 1'b1;
      c_addr_d    = base_q;
      c_wdata_d   = sum_flat[ACC_W-1:0];
      drain_d     = sum_flat >> ACC_W;
      drain_cnt_d = DCW'(LANES - 1);
    end else if (drain_cnt_q != '0) begin
      c_we_d      = 1'b1;
      c_addr_d    = c_addr_q + AW'(1);
      c_wdata_d   = drain_q[ACC_W-1:0];
      drain_d     = drain_q >> ACC_W;
      drain_cnt_d = drain_cnt_q - DCW'(1);
    end

    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && abort && start) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          sm_d    = signed_mode;
          i_d     = '0;
          k_d     = '0;
          g_d     = '0;
        end
      end
      RUN, FLUSH: begin
        cnt_d = cnt_q + 32'd1;
        if (abort) begin
          state_d     = IDLE;
          vld_d       = 1'b0;
          c_we_d      = 1'b0;
          drain_cnt_d = '0;
          lane_clr    = 1'b1;
        end else if (state_q == RUN) begin
          vld_d   = 1'b1;
          first_d = (k_q == '0);
          last_d  = (k_q == KW'(N - 1));
          base_d  = AW'(32'(i_q) * N + 32'(g_q) * LANES);
          if (k_q == KW'(N - 1)) begin
            k_d = '0;
            if (g_q == GW'(G - 1)) begin
              g_d = '0;
              i_d = i_q + KW'(1);
              if (i_q == KW'(N - 1)) begin
                state_d = FLUSH;
              end
            end else begin
              g_d = g_q + GW'(1);
            end
          end else begin
            k_d = k_q + KW'(1);
          end
        end else if (c_we_q && (drain_cnt_q == '0) && !vld_q) begin
          // Last lane of the final group is on the bus this cycle.
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == FLUSH);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      i_q         <= '0;
      k_q         <= '0;
      g_q         <= '0;
      sm_q        <= 1'b0;
      vld_q       <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      base_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      c_we_q      <= 1'b0;
      c_addr_q    <= '0;
      c_wdata_q   <= '0;
      drain_q     <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      k_q         <= k_d;
      g_q         <= g_d;
      sm_q        <= sm_d;
      vld_q       <= vld_d;
      first_q     <= first_d;
      last_q      <= last_d;
      base_q      <= base_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      c_we_q      <= c_we_d;
      c_addr_q    <= c_addr_d;
      c_wdata_q   <= c_wdata_d;
      drain_q     <= drain_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

endmodule

// File: tb/tb_matmul_tile_engine.sv
// Self-checking bench for matmul_tile_engine: three instances (LANES=2,1,8)
// share one A/B image; results are checked against a plain arithmetic model.
module tb_matmul_tile_engine;

  localparam int unsigned N     = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 6;
  localparam int unsigned ACC_W = 19;

  typedef struct {
    int         pat;     // 0 identity A / index B, 1 constant A=B=kval, 2 random
    logic [7:0] kval;
    bit         smode;
    int         exp_c;   // constant expected C element for pat 1
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic                  sm;
  logic [2:0]            start_v, abort_v;
  logic [2:0]            busy_v, done_v, c_we_v;
  logic [2:0][31:0]      cc_v;
  logic [2:0][AW-1:0]    a_addr_v, c_addr_v;
  logic [2:0][DW-1:0]    a_rdata_v;
  logic [2:0][ACC_W-1:0] c_wdata_v;
  logic [2*AW-1:0]       b_addr0;
  logic [2*DW-1:0]       b_rdata0;
  logic [AW-1:0]         b_addr1;
  logic [DW-1:0]         b_rdata1;
  logic [8*AW-1:0]       b_addr2;
  logic [8*DW-1:0]       b_rdata2;

  logic [7:0]       a_mem [64];
  logic [7:0]       b_mem [64];
  logic [ACC_W-1:0] exp_mem [64];
  logic [ACC_W-1:0] c_mem [3][64];
  int               we_cnt [3];
  int               we_base [3];
  int               n_vec = 0;
  int               n_err = 0;
  int               lanes_v [3] = '{2, 1, 8};

  matmul_tile_engine #(.N(N), .DATA_W(DW), .LANES(2)) u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort_v[0]), .signed_mode(sm),
    .busy(busy_v[0]), .done(done_v[0]), .cycle_count(cc_v[0]),
    .a_addr(a_addr_v[0]), .a_rdata(a_rdata_v[0]), .b_addr(b_addr0), .b_rdata(b_rdata0),
    .c_we(c_we_v[0]), .c_addr(c_addr_v[0]), .c_wdata(c_wdata_v[0]));

  matmul_tile_engine #(.N(N), .DATA_W(DW), .LANES(1)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort_v[1]), .signed_mode(sm),
    .busy(busy_v[1]), .done(done_v[1]), .cycle_count(cc_v[1]),
    .a_addr(a_addr_v[1]), .a_rdata(a_rdata_v[1]), .b_addr(b_addr1), .b_rdata(b_rdata1),
    .c_we(c_we_v[1]), .c_addr(c_addr_v[1]), .c_wdata(c_wdata_v[1]));

  matmul_tile_engine #(.N(N), .DATA_W(DW), .LANES(8)) u2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .abort(abort_v[2]), .signed_mode(sm),
    .busy(busy_v[2]), .done(done_v[2]), .cycle_count(cc_v[2]),
    .a_addr(a_addr_v[2]), .a_rdata(a_rdata_v[2]), .b_addr(b_addr2), .b_rdata(b_rdata2),
    .c_we(c_we_v[2]), .c_addr(c_addr_v[2]), .c_wdata(c_wdata_v[2]));

  // Synchronous RAMs with one-cycle read latency.
  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) a_rdata_v[u] <= a_mem[a_addr_v[u]];
    for (int l = 0; l < 2; l++) b_rdata0[l*DW +: DW] <= b_mem[b_addr0[l*AW +: AW]];
    b_rdata1 <= b_mem[b_addr1];
    for (int l = 0; l < 8; l++) b_rdata2[l*DW +: DW] <= b_mem[b_addr2[l*AW +: AW]];
  end

  // C RAM: one sample per cycle, just after the edge.
  always begin
    @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      if (c_we_v[u] === 1'b1) begin
        c_mem[u][c_addr_v[u]] = c_wdata_v[u];
        we_cnt[u]++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sx(input logic [7:0] v, input bit s);
    if (s) return int'($signed(v));
    return int'(v);
  endfunction

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], reduced to ACC_W bits.
  task automatic model(input bit s);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        int acc = 0;
        for (int k = 0; k < 8; k++) acc += sx(a_mem[i*8+k], s) * sx(b_mem[k*8+j], s);
        exp_mem[i*8+j] = ACC_W'(acc);
      end
    end
  endtask

  task automatic load_vec(input vec_t v);
    for (int idx = 0; idx < 64; idx++) begin
      case (v.pat)
        0: begin
          a_mem[idx]   = ((idx / 8) == (idx % 8)) ? 8'd1 : 8'd0;
          b_mem[idx]   = 8'(idx);
          exp_mem[idx] = ACC_W'(idx);
        end
        1: begin
          a_mem[idx]   = v.kval;
          b_mem[idx]   = v.kval;
          exp_mem[idx] = ACC_W'(v.exp_c);
        end
        default: begin
          a_mem[idx] = 8'($urandom);
          b_mem[idx] = 8'($urandom);
        end
      endcase
    end
    if (v.pat == 2) model(v.smode);
    sm = v.smode;
  endtask

  task automatic check_c(input int u, input string name);
    int bad = 0;
    int first = 0;
    for (int idx = 63; idx >= 0; idx--) begin
      if (c_mem[u][idx] !== exp_mem[idx]) begin
        bad++;
        first = idx;
      end
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s u%0d: %0d bad C elements, first idx %0d got %0d expected %0d",
               name, u, bad, first, c_mem[u][first], exp_mem[first]);
    end
  endtask

  task automatic snap_we();
    for (int u = 0; u < 3; u++) we_base[u] = we_cnt[u];
  endtask

  task automatic pulse_start(input logic [2:0] mask);
    start_v = mask;
    step();
    start_v = '0;
  endtask

  task automatic wait_done(input logic [2:0] mask, input int budget, input string name);
    int n = 0;
    while (((done_v & mask) != mask) && (n < budget)) begin
      step();
      n++;
    end
    chk(name, 64'((done_v & mask) == mask), 64'd1);
  endtask

  task automatic check_run(input int u, input string name);
    check_c(u, name);
    chk($sformatf("%s_we_count_u%0d", name, u), 64'(we_cnt[u] - we_base[u]), 64'd64);
    chk($sformatf("%s_cycles_u%0d", name, u), 64'(cc_v[u]),
        64'(512 / lanes_v[u] + lanes_v[u] + 1));
    chk($sformatf("%s_done_u%0d", name, u), 64'(done_v[u]), 64'd1);
    chk($sformatf("%s_busy_u%0d", name, u), 64'(busy_v[u]), 64'd0);
  endtask

  task automatic check_reset_state(input int u, input string name);
    chk($sformatf("%s_busy_u%0d", name, u), 64'(busy_v[u]), 64'd0);
    chk($sformatf("%s_done_u%0d", name, u), 64'(done_v[u]), 64'd0);
    chk($sformatf("%s_cc_u%0d", name, u), 64'(cc_v[u]), 64'd0);
    chk($sformatf("%s_c_we_u%0d", name, u), 64'(c_we_v[u]), 64'd0);
    chk($sformatf("%s_c_addr_u%0d", name, u), 64'(c_addr_v[u]), 64'd0);
    chk($sformatf("%s_c_wdata_u%0d", name, u), 64'(c_wdata_v[u]), 64'd0);
  endtask

  initial begin
    vec_t vecs[8];
    vecs[0] = '{pat: 0, kval: 8'h00, smode: 1'b0, exp_c: 0};
    vecs[1] = '{pat: 1, kval: 8'h80, smode: 1'b1, exp_c: 131072};
    vecs[2] = '{pat: 1, kval: 8'h80, smode: 1'b0, exp_c: 131072};
    vecs[3] = '{pat: 1, kval: 8'hFF, smode: 1'b0, exp_c: 520200};
    vecs[4] = '{pat: 1, kval: 8'hFF, smode: 1'b1, exp_c: 8};
    vecs[5] = '{pat: 2, kval: 8'h00, smode: 1'b1, exp_c: 0};
    vecs[6] = '{pat: 2, kval: 8'h00, smode: 1'b0, exp_c: 0};
    vecs[7] = '{pat: 2, kval: 8'h00, smode: 1'b1, exp_c: 0};

    for (int u = 0; u < 3; u++) we_cnt[u] = 0;
    reset   = 1'b1;
    sm      = 1'b0;
    abort_v = '0;
    start_v = 3'b111;   // reset must dominate start
    step(3);
    for (int u = 0; u < 3; u++) check_reset_state(u, "reset");
    reset   = 1'b0;
    start_v = '0;
    step();
    chk("idle_a_addr", 64'(a_addr_v[0]), 64'd0);

    // Table-driven runs on all three lane configurations at once.
    for (int v = 0; v < 8; v++) begin
      load_vec(vecs[v]);
      snap_we();
      pulse_start(3'b111);
      wait_done(3'b111, 2000, $sformatf("vec%0d_completes", v));
      for (int u = 0; u < 3; u++) check_run(u, $sformatf("vec%0d", v));
    end

    // start pulses mid-run are ignored; exact completion and address timing.
    load_vec('{pat: 2, kval: 8'h00, smode: 1'b1, exp_c: 0});
    snap_we();
    pulse_start(3'b001);                      // now in cycle 0
    chk("cycle0_a_addr", 64'(a_addr_v[0]), 64'd0);
    chk("cycle0_b_addr", 64'(b_addr0), 64'({6'd1, 6'd0}));
    step(9);                                  // cycle 9: i=0 g=1 k=1
    chk("cycle9_a_addr", 64'(a_addr_v[0]), 64'd1);
    chk("cycle9_b_addr", 64'(b_addr0), 64'({6'd11, 6'd10}));
    step();
    pulse_start(3'b001);                      // start during cycle 10
    step(189);
    pulse_start(3'b001);                      // start during cycle 200
    step(57);                                 // cycle 258: last C write
    chk("cycle258_done", 64'(done_v[0]), 64'd0);
    chk("cycle258_busy", 64'(busy_v[0]), 64'd1);
    chk("cycle258_c_we", 64'(c_we_v[0]), 64'd1);
    chk("cycle258_c_addr", 64'(c_addr_v[0]), 64'd63);
    step();
    chk("cycle259_done", 64'(done_v[0]), 64'd1);
    chk("cycle259_busy", 64'(busy_v[0]), 64'd0);
    chk("cycle259_cycles", 64'(cc_v[0]), 64'd259);
    check_c(0, "ignored_start");
    chk("ignored_start_we_count", 64'(we_cnt[0] - we_base[0]), 64'd64);

    // start in DONE launches a new run.
    load_vec('{pat: 2, kval: 8'h00, smode: 1'b0, exp_c: 0});
    snap_we();
    pulse_start(3'b001);
    chk("restart_done_drops", 64'(done_v[0]), 64'd0);
    chk("restart_busy", 64'(busy_v[0]), 64'd1);
    wait_done(3'b001, 600, "restart_completes");
    check_run(0, "restart");

    // abort together with start in DONE returns to IDLE.
    start_v = 3'b001;
    abort_v = 3'b001;
    step();
    start_v = '0;
    abort_v = '0;
    chk("abort_start_done", 64'(done_v[0]), 64'd0);
    chk("abort_start_busy", 64'(busy_v[0]), 64'd0);
    step(3);
    chk("abort_start_stays_idle", 64'(busy_v[0]), 64'd0);

    // abort at cycle 100, then a clean run.
    load_vec('{pat: 2, kval: 8'h00, smode: 1'b1, exp_c: 0});
    pulse_start(3'b001);
    step(100);
    abort_v = 3'b001;
    step();
    abort_v = '0;
    chk("abort_busy", 64'(busy_v[0]), 64'd0);
    chk("abort_done", 64'(done_v[0]), 64'd0);
    snap_we();
    step(20);
    chk("abort_no_writes", 64'(we_cnt[0] - we_base[0]), 64'd0);
    chk("abort_stays_idle", 64'(busy_v[0] | done_v[0]), 64'd0);
    load_vec('{pat: 2, kval: 8'h00, smode: 1'b1, exp_c: 0});
    snap_we();
    pulse_start(3'b001);
    wait_done(3'b001, 600, "post_abort_completes");
    check_run(0, "post_abort");

    // Reset during FLUSH.
    pulse_start(3'b001);
    step(257);
    chk("flush_busy", 64'(busy_v[0]), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_state(0, "flush_reset");
    step();
    chk("flush_reset_idle", 64'(busy_v[0]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
